lu_solve_sequencer: RTL
=======================

Name: lu_solve_sequencer

Overview:
Control FSM that sequences the 3-variable LU equation-solver core through one solve, from request to result display.
- Clears the core, enables it, and waits for its done or error flags under a watchdog.
- Latches the outcome, then time-multiplexes the core's display select so X0, X1 and X2 rotate on the seven-segment bank.
- Sits between the board switches/keys and the solver core in the top level.

Parameters:
TIMEOUT_CYCLES, 4096, max clk cycles in RUN before declaring timeout (>=2)
DWELL_CYCLES, 50000000, clk cycles each result stays displayed (1 s at 50 MHz; >=2)
CLEAR_CYCLES, 2, cycles core_clear is held high before RUN (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  solve request; level, acted on only in IDLE, SHOW or ERROR
hold  in  1  freeze display rotation while high
core_done  in  1  solver core done flag
core_err_ovf  in  1  core overflow error
core_err_dbz  in  1  core divide-by-zero error
core_err_fsm  in  1  core internal FSM error
core_clear  out  1  active-high clear to core (top inverts to the core's reset if needed)
core_en  out  1  enable to core
disp_control  out  2  00 X0, 01 X1, 10 X2, 11 blank/FFFF
busy  out  1  high in CLEAR and RUN
done  out  1  high in SHOW
err_code  out  3  sticky {fsm, dbz, ovf} latched at end of RUN
timeout  out  1  sticky watchdog flag

Behaviour:
Reset values (rst=1 at a clk edge):
- state=IDLE, core_clear=1, core_en=0, disp_control=11.
- busy=0, done=0, err_code=000, timeout=0, all counters 0.
- rst has priority over every other input.

IDLE:
- core_clear=1, disp=11.
- start=1 -> CLEAR; clear err_code, timeout and counters on the same edge.

CLEAR:
- core_clear=1, core_en=0, busy=1.
- Lasts exactly CLEAR_CYCLES cycles -> RUN.

RUN:
- core_clear=0, core_en=1, busy=1.
- Watchdog counter increments each cycle.
- Any of core_err_* =1 -> latch err_code from the sampled flags -> ERROR. Errors win over core_done in the same cycle.
- Else core_done=1 -> SHOW, disp=00, dwell counter=0.
- Else watchdog reaches TIMEOUT_CYCLES-1 -> timeout=1 -> ERROR.
- core_done/err inputs are ignored in every state except RUN.

SHOW:
- core_en=1 (core keeps holding its results), done=1.
- Dwell counter counts 0..DWELL_CYCLES-1 while hold=0; it freezes while hold=1.
- On terminal count: disp advances 00->01->10->00 and the counter returns to 0. It never emits 11 in SHOW.
- start=1 -> CLEAR; this has priority over the rotation step in the same cycle.

ERROR:
- core_en=0, core_clear=0, disp=11, busy=0, done=0.
- err_code and timeout hold.
- start=1 -> CLEAR.

Latency and output rules:
- start seen in IDLE -> core_en high exactly CLEAR_CYCLES+1 edges later.
- core_done seen in RUN -> done=1 on the next cycle.
- All outputs are registered or decoded from the registered state only; no input-to-output combinational path.
- start held high continuously after SHOW/ERROR re-triggers a solve; this is intended.
- A user wanting a single solve must release start.

Counters:
- Watchdog width = clog2(TIMEOUT_CYCLES); dwell width = clog2(DWELL_CYCLES); both saturate-free.
- Unreachable state encodings -> IDLE next cycle.

Decomposition:
- Shared package: state encodings (IDLE, CLEAR, RUN, SHOW, ERROR), disp_control codes (DISP_X0=00, DISP_X1=01, DISP_X2=10, DISP_BLANK=11), err_code bit positions.
- One natural sub-module, display_rotator: dwell counter plus 2-bit select, with inputs load/enable/hold and output sel.

Test Plan:
Run the bench with TIMEOUT_CYCLES=16, DWELL_CYCLES=4, CLEAR_CYCLES=2.
1. Reset then start=1 for 1 cycle -> core_clear high 2 cycles; core_en rises on the 3rd edge after start; busy=1. Pulse core_done after 5 cycles -> done=1 next cycle; disp sequence 00,00,00,00,01,01,01,01,10,... then wraps to 00.
2. In RUN assert core_err_dbz and core_done in the same cycle -> ERROR; err_code=010; done stays 0; disp=11; core_en=0.
3. Core never finishes -> after 16 RUN cycles timeout=1, state ERROR, disp=11. Then start=1 -> timeout cleared, new CLEAR.
4. In SHOW at disp=01 hold=1 for 10 cycles -> disp stays 01; release -> 01 persists for the remaining dwell count, then 10.
5. Assert rst in the middle of RUN -> next edge: core_en=0, core_clear=1, disp=11, err_code=000, busy=0. core_done pulses afterwards are ignored.
6. start held high across a completed solve -> SHOW lasts 1 cycle, then CLEAR re-enters; core_done pulses while in IDLE or CLEAR are ignored.

Source files
------------

// File: rtl/lu_solve_sequencer_pkg.sv
// Shared encodings for the LU solve sequencer: FSM states, display
// select codes and err_code bit positions.
package lu_solve_sequencer_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_SHOW  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [1:0] DISP_X0    = 2'b00;
    localparam logic [1:0] DISP_X1    = 2'b01;
    localparam logic [1:0] DISP_X2    = 2'b10;
    localparam logic [1:0] DISP_BLANK = 2'b11;

    localparam int unsigned ERR_OVF = 0;
    localparam int unsigned ERR_DBZ = 1;
    localparam int unsigned ERR_FSM = 2;

    // X0 -> X1 -> X2 -> X0; the blank code never appears in the rotation
    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        case (sel)
            DISP_X0: next_sel = DISP_X1;
            DISP_X1: next_sel = DISP_X2;
            default: next_sel = DISP_X0;
        endcase
    endfunction

endpackage

// File: rtl/lu_solve_sequencer_display_rotator.sv
// Dwell counter plus 2-bit result select that rotates X0/X1/X2 on the
// seven-segment bank; load restarts at X0, hold freezes the dwell count.
module lu_solve_sequencer_display_rotator
    import lu_solve_sequencer_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       enable,
    input  logic       hold,
    output logic [1:0] sel
);

    localparam int unsigned DW_W = $clog2(DWELL_CYCLES);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

    logic [DW_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
            sel <= DISP_X0;
        end else if (enable && !hold) begin
            if (cnt == DW_LAST) begin
                cnt <= '0;
                sel <= next_sel(sel);
            end else begin
                cnt <= cnt + DW_W'(1);
            end
        end
    end

endmodule

// File: rtl/lu_solve_sequencer.sv
// Control FSM sequencing the 3-variable LU solver core through one solve:
// clear, run under a watchdog, then latch the outcome and rotate results.
module lu_solve_sequencer
    import lu_solve_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned DWELL_CYCLES   = 50000000,
    parameter int unsigned CLEAR_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    input  logic       core_done,
    input  logic       core_err_ovf,
    input  logic       core_err_dbz,
    input  logic       core_err_fsm,
    output logic       core_clear,
    output logic       core_en,
    output logic [1:0] disp_control,
    output logic       busy,
    output logic       done,
    output logic [2:0] err_code,
    output logic       timeout
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

    logic [2:0]       state;
    logic [WD_W-1:0]  wd_cnt;
    logic [CLR_W-1:0] clr_cnt;
    logic [2:0]       core_err;
    logic             restart;
    logic             rot_load;
    logic             rot_enable;
    logic [1:0]       rot_sel;

    always_comb begin
        core_err          = '0;
        core_err[ERR_OVF] = core_err_ovf;
        core_err[ERR_DBZ] = core_err_dbz;
        core_err[ERR_FSM] = core_err_fsm;
    end

    // start is honoured from IDLE, SHOW and ERROR alike, so the restart
    // path is hoisted out of the per-state cases.
    assign restart = start && (state == S_IDLE || state == S_SHOW || state == S_ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wd_cnt   <= '0;
            clr_cnt  <= '0;
            err_code <= '0;
            timeout  <= 1'b0;
        end else if (restart) begin
            state    <= S_CLEAR;
            wd_cnt   <= '0;
            clr_cnt  <= '0;
            err_code <= '0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_SHOW, S_ERROR: ;
                S_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state   <= S_RUN;
                        clr_cnt <= '0;
                        wd_cnt  <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end
                S_RUN: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (core_err != 3'b000) begin
                        err_code <= core_err;
                        state    <= S_ERROR;
                    end else if (core_done) begin
                        state <= S_SHOW;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout <= 1'b1;
                        state   <= S_ERROR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Rotator is held loaded throughout RUN so SHOW always opens on X0
    // with a fresh dwell count; a pending restart suppresses the step.
    assign rot_load   = (state == S_RUN);
    assign rot_enable = (state == S_SHOW) && !start;

    lu_solve_sequencer_display_rotator #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_display_rotator (
        .clk   (clk),
        .rst   (rst),
        .load  (rot_load),
        .enable(rot_enable),
        .hold  (hold),
        .sel   (rot_sel)
    );

    always_comb begin
        core_clear   = 1'b0;
        core_en      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        disp_control = DISP_BLANK;
        case (state)
            S_IDLE:  core_clear = 1'b1;
            S_CLEAR: begin
                core_clear = 1'b1;
                busy       = 1'b1;
            end
            S_RUN: begin
                core_en = 1'b1;
                busy    = 1'b1;
            end
            S_SHOW: begin
                core_en      = 1'b1;
                done         = 1'b1;
                disp_control = rot_sel;
            end
            default: ;
        endcase
    end

endmodule
